wb_gpio_bridge: RTL and testbench
=================================

Name: wb_gpio_bridge

Overview:
- Wishbone slave between the user-area Wishbone port and the user I/O pads.
- Exposes pad output values, output enables and synchronized pad inputs as memory-mapped registers.
- Provides per-pin rising-edge interrupt capture, signalled on user_irq[0].
- Sits in the user project area, fed directly by the wrapper's wbs_* and io_* signals.

Parameters:
IO_PADS, 38, number of user I/O pads; legal range 33..64.
BASE_ADDR, 32'h3000_0000, base of the register window.
ADDR_MASK, 32'hFFFF_FF00, address bits compared against BASE_ADDR.

Ports:
wb_clk_i  in  1  single clock; all logic on its rising edge
wb_rst_i  in  1  synchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  IO_PADS  pad inputs (asynchronous)
io_out  out  IO_PADS  pad output values
io_oeb  out  IO_PADS  pad output enables, active-low
user_irq  out  3  interrupts; [0] = GPIO edge, [2:1] tied 0

Behaviour:
- hit = ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)); offset = wbs_adr_i[7:0]; wbs_adr_i[1:0] ignored.
- Register map. LO = pin bits 31:0; HI = pin bits IO_PADS-1:32 in data bits [IO_PADS-33:0], upper bits read 0.
  - 0x00/0x04 OUT_LO/HI: RW, drives io_out.
  - 0x08/0x0C OEB_LO/HI: RW, drives io_oeb.
  - 0x10/0x14 IN_LO/HI: RO, synchronized inputs.
  - 0x18/0x1C IE_LO/HI: RW, edge interrupt enable.
  - 0x20/0x24 IS_LO/HI: write-1-to-clear, latched edge status.
  - 0x28 ID: RO, 32'h6710_0001.
  - Other offsets in the window: acked, read 0, writes ignored.
- Handshake:
  - ack_next = stb & cyc & hit & ~wbs_ack_o, registered.
  - ack is high exactly one cycle, one cycle after the request is presented. The master holds stb until ack.
  - Back-to-back requests are acked every other cycle.
  - Accesses that miss the window are never acked.
- Writes commit on the same edge that raises ack, byte-lane masked by wbs_sel_i for RW and W1C registers. Bits beyond IO_PADS are not stored.
- wbs_dat_o is registered with ack, valid while ack=1, and is 0 whenever ack=0.
- Input path:
  - io_in passes through two sync flops (s1, s2), then one history flop (s3).
  - IN reads s2, so a pad change is visible after 2 edges.
  - edge = s2 & ~s3.
- Edge status:
  - IS[i] sets on any edge where edge[i] & IE[i].
  - A W1C clear of bit i on the same edge as a set: the set wins.
  - Clearing IE does not clear IS.
- Interrupt output: user_irq[0] = |IS, from registered state. A pad rising edge raises user_irq[0] 3 edges after the io_in transition.
- Reset values (wb_rst_i high at an edge):
  - io_out = 0, io_oeb = all 1s (inputs), IE = 0, IS = 0.
  - s1/s2/s3 = 0, wbs_ack_o = 0, wbs_dat_o = 0, user_irq = 0.
- Reset mid-transaction: a write whose ack edge coincides with reset is discarded. The master must re-issue the request after reset.
- A pad held high through reset produces an edge after reset. It is harmless because IE = 0.

Test Plan:
- Reset, then read 0x08/0x0C/0x28 → 0xFFFF_FFFF, 0x0000_003F, 0x6710_0001; io_oeb = all 1s, io_out = 0.
- Write OUT_LO = 0xA5A5_A5A5 with sel = 4'b0011, then read → 0x0000_A5A5. Ack is 1 cycle, 1 cycle after stb; io_out[15:0] = 16'hA5A5.
- IE_HI = 0x20, then io_in[37] goes 0→1 → IS_HI = 0x20 and user_irq[0] = 1 on the 3rd edge after the change. Write IS_HI = 0x20 → user_irq[0] = 0 the next cycle.
- Same-edge W1C of IS_LO bit 0 and a new edge on pin 0 with IE_LO[0] = 1 → IS_LO[0] remains 1.
- Access at 0x3000_0100 (outside the window) → no ack for 10 cycles. Access at 0x3000_0030 → ack, read 0.
- Assert reset during a write to OUT_LO on its ack edge → OUT_LO = 0 after reset, ack = 0.

Source files
------------

// File: rtl/wb_gpio_bridge.sv
// rtl/wb_gpio_bridge.sv - Wishbone slave exposing user I/O pads as GPIO registers
//
// Purpose:
//   Maps pad output values, pad output enables (active-low), synchronized pad
//   inputs, per-pin rising-edge interrupt enables and latched edge status into
//   a small Wishbone register window. Edge status is summarized on user_irq[0].
//
// Register map (byte offsets within the window, LO = pins 31:0,
// HI = pins IO_PADS-1:32 in data bits [IO_PADS-33:0]):
//   0x00/0x04 OUT  RW     0x08/0x0C OEB  RW     0x10/0x14 IN  RO
//   0x18/0x1C IE   RW     0x20/0x24 IS   W1C    0x28      ID  RO
//   Any other offset in the window is acked, reads 0, ignores writes.
//
// Ports:
//   wb_clk_i            single clock, rising edge
//   wb_rst_i            synchronous active-high reset
//   wbs_stb_i/cyc_i     Wishbone strobe / cycle
//   wbs_we_i            write enable
//   wbs_sel_i[3:0]      byte lane selects
//   wbs_dat_i[31:0]     write data
//   wbs_adr_i[31:0]     byte address
//   wbs_ack_o           one-cycle acknowledge
//   wbs_dat_o[31:0]     read data, valid with ack, 0 otherwise
//   io_in[IO_PADS-1:0]  asynchronous pad inputs
//   io_out[IO_PADS-1:0] pad output values
//   io_oeb[IO_PADS-1:0] pad output enables, active-low
//   user_irq[2:0]       [0] = GPIO edge interrupt, [2:1] tied low

module wb_gpio_bridge #(
   parameter int          IO_PADS   = 38,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_dat_i,
   input  logic [31:0]        wbs_adr_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   input  logic [IO_PADS-1:0] io_in,
   output logic [IO_PADS-1:0] io_out,
   output logic [IO_PADS-1:0] io_oeb,
   output logic [2:0]         user_irq
);

   localparam logic [31:0] ID_VALUE = 32'h6710_0001;

   // Registers come in LO/HI pairs; wbs_adr_i[7:3] picks the pair and
   // wbs_adr_i[2] picks the half.
   localparam logic [4:0] PAIR_OUT = 5'd0;
   localparam logic [4:0] PAIR_OEB = 5'd1;
   localparam logic [4:0] PAIR_IN  = 5'd2;
   localparam logic [4:0] PAIR_IE  = 5'd3;
   localparam logic [4:0] PAIR_IS  = 5'd4;
   localparam logic [5:0] WORD_ID  = 6'd10;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [IO_PADS-1:0] out_q, out_d;
   logic [IO_PADS-1:0] oeb_q, oeb_d;
   logic [IO_PADS-1:0] ie_q,  ie_d;
   logic [IO_PADS-1:0] is_q,  is_d;
   logic [IO_PADS-1:0] s1_q,  s1_d;
   logic [IO_PADS-1:0] s2_q,  s2_d;
   logic [IO_PADS-1:0] s3_q,  s3_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;

   // ------------------------------------------------------------------
   // Decode and write-data alignment
   // ------------------------------------------------------------------
   logic               hit;
   logic               wr_en;
   logic [4:0]         pair;
   logic               hi_half;
   logic [IO_PADS-1:0] wmask;
   logic [IO_PADS-1:0] wdata;

   always_comb begin
      hit     = ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
      pair    = wbs_adr_i[7:3];
      hi_half = wbs_adr_i[2];
      // The cycle that raises ack is also the cycle whose edge commits the write.
      ack_d   = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
      wr_en   = ack_d & wbs_we_i;

      // Expand the 32-bit bus word onto pin positions: a LO access touches
      // pins 0..31, a HI access pins 32..IO_PADS-1. Pins beyond IO_PADS
      // simply have no storage, so those data bits are dropped here.
      wmask = '0;
      wdata = '0;
      for (int i = 0; i < IO_PADS; i++) begin
         wmask[i] = wbs_sel_i[(i % 32) / 8] & (hi_half == (i >= 32));
         wdata[i] = wbs_dat_i[i % 32];
      end
   end

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   logic [IO_PADS-1:0] rd_reg;
   logic [63:0]        rd_wide;
   logic [31:0]        rd_word;

   always_comb begin
      rd_reg = '0;
      case (pair)
         PAIR_OUT: rd_reg = out_q;
         PAIR_OEB: rd_reg = oeb_q;
         PAIR_IN:  rd_reg = s2_q;
         PAIR_IE:  rd_reg = ie_q;
         PAIR_IS:  rd_reg = is_q;
         default:  rd_reg = '0;
      endcase

      // Zero-extend to 64 so unimplemented HI bits read back as 0.
      rd_wide = 64'(rd_reg);
      rd_word = hi_half ? rd_wide[63:32] : rd_wide[31:0];

      if (wbs_adr_i[7:2] == WORD_ID) begin
         rd_word = ID_VALUE;
      end else if (pair > PAIR_IS) begin
         rd_word = '0;
      end
   end

   // ------------------------------------------------------------------
   // Register next-state
   // ------------------------------------------------------------------
   logic [IO_PADS-1:0] edge_det;
   logic [IO_PADS-1:0] is_clr;

   always_comb begin
      out_d = out_q;
      oeb_d = oeb_q;
      ie_d  = ie_q;

      if (wr_en && pair == PAIR_OUT) out_d = (out_q & ~wmask) | (wdata & wmask);
      if (wr_en && pair == PAIR_OEB) oeb_d = (oeb_q & ~wmask) | (wdata & wmask);
      if (wr_en && pair == PAIR_IE)  ie_d  = (ie_q  & ~wmask) | (wdata & wmask);

      // Two-flop synchronizer followed by a history flop for edge detection.
      s1_d = io_in;
      s2_d = s1_q;
      s3_d = s2_q;
      edge_det = s2_q & ~s3_q;

      // Clear is applied first and the new edge ORed in afterwards, so a
      // simultaneous edge is never lost to a software clear.
      is_clr = (wr_en && pair == PAIR_IS) ? (wdata & wmask) : '0;
      is_d   = (is_q & ~is_clr) | (edge_det & ie_q);

      dat_d = ack_d ? rd_word : 32'h0;
   end

   // ------------------------------------------------------------------
   // Flops
   // ------------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         out_q <= '0;
         oeb_q <= '1;
         ie_q  <= '0;
         is_q  <= '0;
         s1_q  <= '0;
         s2_q  <= '0;
         s3_q  <= '0;
         ack_q <= 1'b0;
         dat_q <= 32'h0;
      end else begin
         out_q <= out_d;
         oeb_q <= oeb_d;
         ie_q  <= ie_d;
         is_q  <= is_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         s3_q  <= s3_d;
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = out_q;
   assign io_oeb    = oeb_q;
   assign user_irq  = {2'b00, |is_q};

endmodule

// File: tb/tb_wb_gpio_bridge.sv
// tb/tb_wb_gpio_bridge.sv - scoreboard bench for wb_gpio_bridge

module tb_wb_gpio_bridge;

   localparam int N = 38;

   logic          clk = 1'b0;
   logic          rst;
   logic          stb, cyc, we;
   logic [3:0]    sel;
   logic [31:0]   dat_i, adr;
   logic          ack;
   logic [31:0]   dat_o;
   logic [N-1:0]  io_in, io_out, io_oeb;
   logic [2:0]    irq;

   wb_gpio_bridge #(
      .IO_PADS   (N),
      .BASE_ADDR (32'h3000_0000),
      .ADDR_MASK (32'hFFFF_FF00)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oeb    (io_oeb),
      .user_irq  (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every ack pops one scoreboard entry; reads compare data.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got ack with empty scoreboard, dat=%h", dat_o);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.chk) check(mon_e.name, 64'(dat_o), 64'(mon_e.exp));
         end
      end
   end

   // One acked access; called and returns at #1 after a rising edge.
   task automatic wb(input logic we_v, input logic [31:0] adr_v, input logic [31:0] dat_v,
                     input logic [3:0] sel_v, input logic [31:0] exp_v, input string name);
      exp_t e;
      e.chk  = !we_v;
      e.exp  = exp_v;
      e.name = name;
      sbq.push_back(e);
      stb = 1'b1; cyc = 1'b1; we = we_v; adr = adr_v; dat_i = dat_v; sel = sel_v;
      @(posedge clk); #1;
      check({name, "_ack_rise"}, 64'(ack), 64'd1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check({name, "_ack_fall"}, 64'(ack), 64'd0);
      check({name, "_dat_idle"}, 64'(dat_o), 64'd0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      wb(1'b0, a, 32'h0, 4'hF, exp, name);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
      wb(1'b1, a, d, s, 32'h0, name);
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int miss_acks;
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      dat_i = '0; adr = '0; io_in = '0;
      step(3);
      rst = 1'b0;

      // Reset state
      check("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
      check("rst_out", 64'(io_out), 64'h0);
      check("rst_irq", 64'(irq), 64'h0);
      check("rst_ack", 64'(ack), 64'h0);
      check("rst_dat", 64'(dat_o), 64'h0);

      rd(32'h3000_0008, 32'hFFFF_FFFF, "rd_oeb_lo");
      rd(32'h3000_000C, 32'h0000_003F, "rd_oeb_hi");
      rd(32'h3000_0028, 32'h6710_0001, "rd_id");

      // Byte-lane masked write
      wr(32'h3000_0000, 32'hA5A5_A5A5, 4'b0011, "wr_out_lo");
      check("io_out_a5", 64'(io_out), 64'h00_0000_A5A5);
      rd(32'h3000_0000, 32'h0000_A5A5, "rd_out_lo");

      // Unimplemented HI bits are not stored
      wr(32'h3000_000C, 32'hFFFF_FFFF, 4'hF, "wr_oeb_hi");
      rd(32'h3000_000C, 32'h0000_003F, "rd_oeb_hi2");
      wr(32'h3000_0008, 32'h0000_0000, 4'hF, "wr_oeb_lo");
      check("io_oeb_lo0", 64'(io_oeb), 64'h3F_0000_0000);

      // Input path
      io_in = 38'h0A_1234_5678;
      step(3);
      rd(32'h3000_0010, 32'h1234_5678, "rd_in_lo");
      rd(32'h3000_0014, 32'h0000_000A, "rd_in_hi");

      // Edge interrupt on pin 37: irq on the 3rd edge after the change
      wr(32'h3000_001C, 32'h0000_0020, 4'hF, "wr_ie_hi");
      io_in[37] = 1'b1;
      step(1); check("irq_e1", 64'(irq), 64'h0);
      step(1); check("irq_e2", 64'(irq), 64'h0);
      step(1); check("irq_e3", 64'(irq), 64'h1);
      rd(32'h3000_0024, 32'h0000_0020, "rd_is_hi");
      wr(32'h3000_0024, 32'h0000_0020, 4'hF, "clr_is_hi");
      check("irq_clr", 64'(irq), 64'h0);
      rd(32'h3000_0024, 32'h0000_0000, "rd_is_hi0");

      // Same-edge clear and set on pin 0: set wins
      wr(32'h3000_0018, 32'h0000_0001, 4'hF, "wr_ie_lo");
      io_in[0] = 1'b1;
      step(4);
      check("irq_pin0", 64'(irq), 64'h1);
      io_in[0] = 1'b0;
      step(4);
      io_in[0] = 1'b1;
      step(2);
      wr(32'h3000_0020, 32'h0000_0001, 4'hF, "clr_is_lo_race");
      rd(32'h3000_0020, 32'h0000_0001, "rd_is_lo_race");
      wr(32'h3000_0020, 32'h0000_0001, 4'hF, "clr_is_lo");
      rd(32'h3000_0020, 32'h0000_0000, "rd_is_lo0");
      check("irq_all_clr", 64'(irq), 64'h0);

      // Outside the window: never acked
      miss_acks = 0;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
      repeat (10) begin
         @(posedge clk); #1;
         if (ack !== 1'b0) miss_acks++;
      end
      stb = 1'b0; cyc = 1'b0;
      check("miss_no_ack", 64'(miss_acks), 64'd0);
      step(1);
      rd(32'h3000_0030, 32'h0000_0000, "rd_hole");

      // Reset coincident with the ack edge of a write discards it
      rst = 1'b1;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0000; dat_i = 32'hFFFF_FFFF; sel = 4'hF;
      step(1);
      check("rstw_ack", 64'(ack), 64'h0);
      check("rstw_out", 64'(io_out), 64'h0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0; rst = 1'b0;
      step(1);
      check("rstw_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
      rd(32'h3000_0000, 32'h0000_0000, "rd_out_after_rst");
      rd(32'h3000_0018, 32'h0000_0000, "rd_ie_after_rst");
      step(4);
      check("irq_after_rst", 64'(irq), 64'h0);

      step(3);
      check("sb_empty", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
